prim_word_serializer: RTL and testbench
=======================================

Name: prim_word_serializer

Overview:
- Transmit side of the primitive-type byte stream: accepts full-width integer words and sends them as bytes, LSB first, over a valid/ready byte interface.
- Sits between producers of int/logic-vector values and the existing byte-stream receiver, which reassembles words.
- One word register holds the word in flight. A byte counter and a two-state FSM sequence the bytes. Back-to-back words are accepted with no bubble.

Parameters:
- WORD_W, 32, word width in bits. Must be a multiple of 8 and at least 16; elaboration error otherwise.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion is asynchronous.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  serializer can take a word this cycle.
- in_data  input  WORD_W  word to send.
- in_last  input  1  word ends a frame; carried to the final byte.
- out_valid  output  1  byte on out_data is valid.
- out_ready  input  1  receiver accepts a byte this cycle.
- out_data  output  8  current byte.
- out_last  output  1  high on the final byte of a word accepted with in_last=1.
- busy  output  1  word in flight (state SEND).
- word_count  output  CNT_W  number of words fully transmitted.

Behaviour:
- Constants:
  - BYTES = WORD_W/8.
  - Byte counter idx is clog2(BYTES) bits and ranges 0..BYTES-1.
- FSM states: IDLE, SEND.
- Reset (rst_n low, asynchronous):
  - state=IDLE, idx=0, word register=0, frame-last flag=0.
  - out_valid=0, out_data=0, out_last=0, busy=0, word_count=0.
  - in_ready reads 1 once the reset value is held, since it is combinational from IDLE.
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Byte transfer = out_valid && out_ready.
- in_ready (combinational) = (state==IDLE) || (transfer && idx==BYTES-1). It depends on out_ready, but there is no combinational path from in_valid to out_*.
- IDLE:
  - On accept: latch in_data and in_last, set idx=0, go to SEND.
  - The first byte, in_data[7:0], is presented with out_valid=1 in the next cycle. Latency from accept to first byte is 1 cycle.
- SEND:
  - out_data = word[8*idx +: 8]; out_valid=1.
  - out_last = frame-last flag && idx==BYTES-1.
  - On transfer with idx<BYTES-1: idx++.
  - On transfer with idx==BYTES-1: word_count++ (wraps modulo 2^CNT_W, no saturation).
    - If an accept happens in the same cycle: load the new word, set idx=0, stay in SEND. No idle cycle between words.
    - Otherwise: go to IDLE, out_valid=0, out_last=0.
- Stall: while out_valid && !out_ready, out_data, out_last and idx hold stable. in_valid changes are ignored.
- in_data and in_last are sampled only on accept.
- Simultaneous events:
  - An accept in the last-byte cycle takes priority over the return to IDLE.
  - The word_count increment and the new load happen in the same cycle.
- Reset mid-word: the in-flight word is dropped. The receiver sees out_valid fall without out_last, and word_count is not incremented.
- Throughput: one byte per cycle when out_ready is held high. A sustained input stream gives BYTES cycles per word.

Decomposition:
- prim_stream_pkg holds:
  - typedef byte_t (logic [7:0]).
  - enum ser_state_e {IDLE, SEND}.
  - function bytes_of(int width) returning width/8.
  - Shared with the receiver.
- No sub-module. FSM, counter and word register fit in a single module of about 150 lines.

Test Plan:
- Reset, then in_data=32'hDEADBEEF, in_last=0, out_ready=1:
  - bytes EF, BE, AD, DE on four consecutive cycles, first byte one cycle after accept.
  - out_last=0 throughout; word_count=1.
- Two words back-to-back, 32'h03020100 then 32'h07060504 with in_last=1, out_ready=1:
  - bytes 00..07 on eight consecutive cycles.
  - in_ready=1 in the last-byte cycle of word 1.
  - out_last=1 only on byte 07; word_count=2.
- Word 32'h11223344, out_ready held 0 for 3 cycles on byte 1 (value 33):
  - out_data=33 stable for those cycles, then sequence 44, 33, 22, 11 completes.
  - in_ready=0 during the stall.
- rst_n pulsed low after the second byte of 32'hCAFEF00D:
  - out_valid drops asynchronously; word_count=0; in_ready=1 after release.
  - Next word 32'h00000001 sends 01, 00, 00, 00.
- Word-counter wrap with CNT_W=4: 16 words -> word_count returns to 0.
- WORD_W=16, in_data=16'hA55A, in_last=1 -> bytes 5A then A5, out_last=1 on A5.

Source files
------------

// File: rtl/prim_stream_pkg.sv
// rtl/prim_stream_pkg.sv - shared types and helpers for the primitive byte stream
package prim_stream_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   function automatic int bytes_of(int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/prim_word_serializer.sv
// rtl/prim_word_serializer.sv - splits full-width words into an LSB-first byte stream
module prim_word_serializer
   import prim_stream_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_last,
   output logic              busy,
   output logic [CNT_W-1:0]  word_count
);

   localparam int BYTES = bytes_of(WORD_W);
   localparam int IDX_W = $clog2(BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   if (((WORD_W % 8) != 0) || (WORD_W < 16)) begin : g_bad_width
      $error("prim_word_serializer: WORD_W must be a multiple of 8 and at least 16");
   end

   ser_state_e        state;
   logic [WORD_W-1:0] word;
   logic [IDX_W-1:0]  idx;
   logic              frame_last;
   byte_t             cur_byte;
   logic              xfer;
   logic              accept;
   logic              at_last;

   assign out_valid = (state == SEND);
   assign busy      = (state == SEND);
   assign at_last   = (idx == LAST_IDX);
   assign xfer      = out_valid && out_ready;
   // Taking a new word in the final-byte cycle is what removes the bubble between words.
   assign in_ready  = (state == IDLE) || (xfer && at_last);
   assign accept    = in_valid && in_ready;
   assign cur_byte  = word[{idx, 3'b000} +: 8];
   assign out_data  = cur_byte;
   assign out_last  = out_valid && frame_last && at_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word       <= '0;
         idx        <= '0;
         frame_last <= 1'b0;
         word_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  word       <= in_data;
                  frame_last <= in_last;
                  idx        <= '0;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (xfer) begin
                  if (!at_last) begin
                     idx <= idx + IDX_W'(1);
                  end else begin
                     word_count <= word_count + CNT_W'(1);
                     idx        <= '0;
                     if (accept) begin
                        word       <= in_data;
                        frame_last <= in_last;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prim_word_serializer.sv
// tb/tb_prim_word_serializer.sv - directed self-checking bench for prim_word_serializer
module tb_prim_word_serializer;

   logic clk;
   logic rst_n;

   logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last, busy;
   logic [31:0] in_data;
   logic [7:0]  out_data;
   logic [15:0] word_count;

   logic        in_valid_1, in_ready_1, in_last_1, out_valid_1, out_ready_1, out_last_1, busy_1;
   logic [31:0] in_data_1;
   logic [7:0]  out_data_1;
   logic [3:0]  word_count_1;

   logic        in_valid_2, in_ready_2, in_last_2, out_valid_2, out_ready_2, out_last_2, busy_2;
   logic [15:0] in_data_2;
   logic [7:0]  out_data_2;
   logic [15:0] word_count_2;

   int checks = 0;
   int errors = 0;
   int accepts;
   int bytes_seen;
   logic [31:0] wc_mid;
   logic [31:0] exp_word;

   prim_word_serializer #(.WORD_W(32), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .word_count(word_count)
   );

   prim_word_serializer #(.WORD_W(32), .CNT_W(4)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
      .in_data(in_data_1), .in_last(in_last_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
      .out_data(out_data_1), .out_last(out_last_1), .busy(busy_1), .word_count(word_count_1)
   );

   prim_word_serializer #(.WORD_W(16), .CNT_W(16)) u_dut_16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_2), .in_ready(in_ready_2),
      .in_data(in_data_2), .in_last(in_last_2), .out_valid(out_valid_2), .out_ready(out_ready_2),
      .out_data(out_data_2), .out_last(out_last_2), .busy(busy_2), .word_count(word_count_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
      in_valid_1 = 0; in_data_1 = '0; in_last_1 = 0; out_ready_1 = 0;
      in_valid_2 = 0; in_data_2 = '0; in_last_2 = 0; out_ready_2 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", {24'b0, out_data}, 32'd0);
      chk("rst_out_last", {31'b0, out_last}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_word_count", {16'b0, word_count}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;

      // Single word DEADBEEF, first byte one cycle after accept
      next_cycle();
      in_valid = 1; in_data = 32'hDEADBEEF; in_last = 0; out_ready = 1;
      @(negedge clk);
      chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
      chk("t1_no_byte_yet", {31'b0, out_valid}, 32'd0);
      next_cycle();
      in_valid = 0;
      exp_word = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_valid", {31'b0, out_valid}, 32'd1);
         chk("t1_data", {24'b0, out_data}, {24'b0, exp_word[7:0]});
         chk("t1_last", {31'b0, out_last}, 32'd0);
         exp_word = exp_word >> 8;
         next_cycle();
      end
      @(negedge clk);
      chk("t1_idle_valid", {31'b0, out_valid}, 32'd0);
      chk("t1_busy", {31'b0, busy}, 32'd0);
      chk("t1_count", {16'b0, word_count}, 32'd1);

      // Back-to-back 03020100 then 07060504 with frame end
      next_cycle();
      in_valid = 1; in_data = 32'h03020100; in_last = 0;
      next_cycle();
      in_data = 32'h07060504; in_last = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t2_valid", {31'b0, out_valid}, 32'd1);
         chk("t2_data", {24'b0, out_data}, i);
         chk("t2_last", {31'b0, out_last}, (i == 7) ? 32'd1 : 32'd0);
         chk("t2_in_ready", {31'b0, in_ready}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
         next_cycle();
         if (i == 3) in_valid = 0;
      end
      @(negedge clk);
      chk("t2_idle_valid", {31'b0, out_valid}, 32'd0);
      chk("t2_count", {16'b0, word_count}, 32'd3);

      // Stall on byte 1 of 11223344; producer activity during the stall is ignored
      next_cycle();
      in_valid = 1; in_data = 32'h11223344; in_last = 0;
      next_cycle();
      in_valid = 0;
      @(negedge clk);
      chk("t3_b0", {24'b0, out_data}, 32'h44);
      next_cycle();
      out_ready = 0; in_valid = 1; in_data = 32'hFFFFFFFF; in_last = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_stall_data", {24'b0, out_data}, 32'h33);
         chk("t3_stall_valid", {31'b0, out_valid}, 32'd1);
         chk("t3_stall_in_ready", {31'b0, in_ready}, 32'd0);
         next_cycle();
      end
      out_ready = 1; in_valid = 0; in_last = 0;
      exp_word = 32'h00112233;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_data", {24'b0, out_data}, {24'b0, exp_word[7:0]});
         chk("t3_last", {31'b0, out_last}, 32'd0);
         exp_word = exp_word >> 8;
         next_cycle();
      end
      @(negedge clk);
      chk("t3_idle_valid", {31'b0, out_valid}, 32'd0);
      chk("t3_count", {16'b0, word_count}, 32'd4);

      // Reset in the middle of CAFEF00D
      next_cycle();
      in_valid = 1; in_data = 32'hCAFEF00D; in_last = 1;
      next_cycle();
      in_valid = 0; in_last = 0;
      @(negedge clk);
      chk("t4_b0", {24'b0, out_data}, 32'h0D);
      next_cycle();
      @(negedge clk);
      chk("t4_b1", {24'b0, out_data}, 32'hF0);
      next_cycle();
      chk("t4_b2_pending", {24'b0, out_data}, 32'hFE);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t4_async_valid", {31'b0, out_valid}, 32'd0);
      chk("t4_async_last", {31'b0, out_last}, 32'd0);
      chk("t4_async_count", {16'b0, word_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t4_in_ready", {31'b0, in_ready}, 32'd1);
      next_cycle();
      in_valid = 1; in_data = 32'h00000001; in_last = 0;
      next_cycle();
      in_valid = 0;
      exp_word = 32'h00000001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_valid", {31'b0, out_valid}, 32'd1);
         chk("t4_data", {24'b0, out_data}, {24'b0, exp_word[7:0]});
         exp_word = exp_word >> 8;
         next_cycle();
      end
      @(negedge clk);
      chk("t4_count", {16'b0, word_count}, 32'd1);

      // Sixteen back-to-back words on the 4-bit counter instance
      next_cycle();
      in_valid_1 = 1; in_data_1 = 32'h0; out_ready_1 = 1;
      accepts = 0; bytes_seen = 0; wc_mid = 32'hFFFFFFFF;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (in_valid_1 && in_ready_1) accepts++;
         if (out_valid_1) bytes_seen++;
         if (bytes_seen == 61 && out_valid_1) wc_mid = {28'b0, word_count_1};
         if (accepts == 16 && !out_valid_1 && c > 0) break;
         next_cycle();
         if (accepts == 16) in_valid_1 = 0;
         in_data_1 = {4{accepts[7:0]}};
      end
      chk("t5_bytes", bytes_seen, 32'd64);
      chk("t5_count_15", wc_mid, 32'd15);
      chk("t5_count_wrap", {28'b0, word_count_1}, 32'd0);

      // 16-bit word instance
      next_cycle();
      in_valid_2 = 1; in_data_2 = 16'hA55A; in_last_2 = 1; out_ready_2 = 1;
      next_cycle();
      in_valid_2 = 0; in_last_2 = 0;
      @(negedge clk);
      chk("t6_b0", {24'b0, out_data_2}, 32'h5A);
      chk("t6_b0_last", {31'b0, out_last_2}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("t6_b1", {24'b0, out_data_2}, 32'hA5);
      chk("t6_b1_last", {31'b0, out_last_2}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("t6_idle_valid", {31'b0, out_valid_2}, 32'd0);
      chk("t6_count", {16'b0, word_count_2}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
